pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register, the next generation of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic control vector and a data payload between two pipeline stages with a valid/ready handshake and a two-entry skid buffer, so back-pressure never drops or duplicates an instruction. It also provides a flush that inserts a bubble, an explicit bubble flag for the forwarding unit, and saturating stall and bubble counters for performance analysis.

## Interface
- CTRL_W, 10, width of the control vector; forced to 0 in every bubble.
- DATA_W, 128, width of the data payload (PC, immediate, operands, register indices, packed by the instantiating stage).
- CNT_W, 16, width of each performance counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-low (0 = reset).
- flush  in  1  discard all held entries and any input presented this cycle.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented to the downstream stage.
- out_ready  in  1  downstream stage consumes the presented entry.
- out_ctrl  out  CTRL_W  presented control vector.
- out_data  out  DATA_W  presented payload.
- out_bubble  out  1  equals ~out_valid; the forwarding unit must ignore the presented entry.
- stall_cnt  out  CNT_W  number of cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  number of non-reset cycles with out_valid=0.

## Operation
- Storage: main register (drives out_*) and skid register, each with its own valid bit.
- States: EMPTY (no valid entry), FULL (main valid, skid empty), SKID (both valid).
- in_ready = ~skid_valid. It is driven from a flop only, with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush. Consume = out_valid & out_ready.
- EMPTY: accept -> main <= in, go to FULL.
- FULL: consume & accept -> main <= in, stay in FULL. Consume only -> EMPTY. Accept only -> skid <= in, go to SKID. Neither -> hold.
- SKID: consume -> main <= skid, skid cleared, go to FULL. Otherwise hold. in_ready=0, so no accept is possible.
- Ordering: entries leave in the order they were accepted.
- Flush, checked after reset: next state is EMPTY. Both valid bits and the main ctrl/data registers are cleared. The input of the flush cycle is dropped, even if in_ready=1.
- Bubble rule: whenever out_valid=0, out_ctrl=0 and out_data=0. Every transition into EMPTY loads the main register with zeros.
- Counters increment by 1 per qualifying cycle, saturate at 2^CNT_W-1, and clear only on reset. Flush does not clear them. The stall condition is evaluated on the registered outputs of the current cycle.

## Timing
- Reset (rst=0 at an edge) gives: out_valid=0, out_bubble=1, out_ctrl=0, out_data=0, in_ready=1, skid empty, stall_cnt=0, bubble_cnt=0. Inputs presented during a reset cycle are ignored.
- Reset applied mid-operation discards all entries at that edge, including an entry held in SKID.
- Latency: an entry accepted at edge N appears on out_* after edge N when the main register is free or consumed at N. An entry that lands in skid appears on the edge after the first consume.
- Throughput: 1 entry per cycle while out_ready=1.
- in_ready falls the cycle after SKID is entered and rises the cycle after the first consume in SKID.
- Flush at edge N gives out_valid=0 from N+1. Accepts resume at N+1 if flush=0.
- Flush together with consume: the consumed entry counts as delivered downstream, and the stage still becomes EMPTY.
- Counter at saturation: holds its value, with no wrap.

## Test plan
- Reset then stream: hold rst=0 for 2 cycles, then feed ctrl=0x3FF, data=1,2,3 with out_ready=1 -> out_valid is 1 from the cycle after the first accept, and data appears as 1,2,3 on consecutive cycles. bubble_cnt=1, counting only the first post-reset cycle.
- Back-pressure: stream data 10,11,12 with out_ready=0 from the second cycle -> 10 is held, 11 goes to skid, in_ready=0, 12 is held upstream. Raise out_ready -> output is 10,11,12 in order, none lost or duplicated. stall_cnt equals the number of low-ready cycles.
- Flush in SKID: with both entries valid, pulse flush together with in_valid (data 0x55) -> next cycle out_valid=0, out_ctrl=0, out_data=0, out_bubble=1, in_ready=1, and 0x55 is never emitted.
- Reset mid-stall: in SKID with out_ready=0, assert rst=0 for 1 cycle -> all outputs at reset values, both counters at 0.
- Saturation: with CNT_W=4, hold out_ready=0 with a valid entry for 20 cycles -> stall_cnt stops at 15 and holds at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a valid/ready
// handshake and a two-entry skid buffer. Back-pressure never drops or
// duplicates an entry; flush turns the stage into a bubble; two saturating
// counters record stall and bubble cycles for performance analysis.
module pipe_stage_skid #(
   parameter int unsigned CTRL_W = 10,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic              out_bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing held
      FULL  = 2'd1,   // main holds an entry, skid empty
      SKID  = 2'd2    // main and skid both hold entries
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   logic              main_valid;
   logic              skid_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic              accept;
   logic              consume;

   // in_ready is a flop, so accept never depends on out_ready in the same cycle.
   assign accept  = in_valid & in_ready & ~flush;
   assign consume = main_valid & out_ready;

   assign out_valid  = main_valid;
   assign out_ctrl   = main_ctrl;
   assign out_data   = main_data;
   assign out_bubble = ~main_valid;

   // Handshake FSM: owns both valid bits, the registered in_ready and the main register.
   always_ff @(posedge clk) begin
      // NOTE: every flop in a clocked block is assigned with <= so all of them
      // see the pre-edge values of each other, whatever the statement order.
      if (!rst) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         main_ctrl  <= '0;
         main_data  <= '0;
      end else if (flush) begin
         // A consume in this cycle still completes downstream; everything
         // else, including this cycle's input, is discarded.
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         main_ctrl  <= '0;
         main_data  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  main_ctrl  <= in_ctrl;
                  main_data  <= in_data;
                  main_valid <= 1'b1;
                  state      <= FULL;
               end
            end
            FULL: begin
               if (consume && accept) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end else if (consume) begin
                  // Entering EMPTY always leaves a zero bubble on the outputs.
                  main_ctrl  <= '0;
                  main_data  <= '0;
                  main_valid <= 1'b0;
                  state      <= EMPTY;
               end else if (accept) begin
                  skid_valid <= 1'b1;
                  in_ready   <= 1'b0;
                  state      <= SKID;
               end
            end
            SKID: begin
               if (consume) begin
                  main_ctrl  <= skid_ctrl;
                  main_data  <= skid_data;
                  skid_valid <= 1'b0;
                  in_ready   <= 1'b1;
                  state      <= FULL;
               end
            end
            default: begin
               state      <= EMPTY;
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
               in_ready   <= 1'b1;
               main_ctrl  <= '0;
               main_data  <= '0;
            end
         endcase
      end
   end

   // Skid payload capture: loaded only when an accept arrives while main is stalled.
   always_ff @(posedge clk) begin
      // NOTE: the skid payload has no reset; skid_valid alone decides whether
      // it means anything, and it is never visible on the outputs directly.
      if (state == FULL && accept && !consume) begin
         skid_ctrl <= in_ctrl;
         skid_data <= in_data;
      end
   end

   // Saturating performance counters, evaluated on this cycle's registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
         if (!main_valid && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a scoreboard queue holds every
// accepted entry and is compared in order against every consumed entry;
// directed checks cover reset, back-pressure, flush, mid-stall reset and
// counter saturation (on a second, narrow-counter instance).
module tb_pipe_stage_skid;

   localparam int CTRL_W = 10;
   localparam int DATA_W = 128;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              out_bubble;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   // Narrow instance used for the counter saturation check.
   logic              s_rst;
   logic              s_flush;
   logic              s_in_valid;
   logic              s_in_ready;
   logic [3:0]        s_in_ctrl;
   logic [7:0]        s_in_data;
   logic              s_out_valid;
   logic              s_out_ready;
   logic [3:0]        s_out_ctrl;
   logic [7:0]        s_out_data;
   logic              s_out_bubble;
   logic [3:0]        s_stall_cnt;
   logic [3:0]        s_bubble_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [CTRL_W+DATA_W-1:0] sb_q[$];

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .out_bubble (out_bubble),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   pipe_stage_skid #(.CTRL_W(4), .DATA_W(8), .CNT_W(4)) dut_sat (
      .clk        (clk),
      .rst        (s_rst),
      .flush      (s_flush),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_ctrl    (s_in_ctrl),
      .in_data    (s_in_data),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_ctrl   (s_out_ctrl),
      .out_data   (s_out_data),
      .out_bubble (s_out_bubble),
      .stall_cnt  (s_stall_cnt),
      .bubble_cnt (s_bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"},  160'(out_valid),  160'(0));
      check({tag, "_out_bubble"}, 160'(out_bubble), 160'(1));
      check({tag, "_out_ctrl"},   160'(out_ctrl),   160'(0));
      check({tag, "_out_data"},   160'(out_data),   160'(0));
      check({tag, "_in_ready"},   160'(in_ready),   160'(1));
      check({tag, "_stall_cnt"},  160'(stall_cnt),  160'(0));
      check({tag, "_bubble_cnt"}, 160'(bubble_cnt), 160'(0));
   endtask

   // Scoreboard: at mid-cycle, pop and compare on consume, push on accept,
   // then drop everything held if the stage is being flushed or reset.
   always @(negedge clk) begin
      logic [CTRL_W+DATA_W-1:0] exp_e;
      if (rst) begin
         if (out_valid && out_ready) begin
            check("sb_nonempty", 160'(sb_q.size() != 0), 160'(1));
            if (sb_q.size() != 0) begin
               exp_e = sb_q.pop_front();
               check("sb_entry", 160'({out_ctrl, out_data}), 160'(exp_e));
            end
         end
         if (in_valid && in_ready && !flush) sb_q.push_back({in_ctrl, in_data});
      end
      if (!rst || flush) sb_q.delete();
   end

   initial begin
      rst         = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b0;
      drive(1'b1, 10'h2AA, 128'hDEAD);   // presented during reset, must be ignored
      s_rst       = 1'b0;
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      s_in_ctrl   = 4'h0;
      s_in_data   = 8'h00;
      s_out_ready = 1'b0;

      // ---- Reset, then stream 1,2,3 at full throughput ----
      step();
      step();
      check_reset_state("reset");
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 10'h3FF, 128'd1);
      step();
      check("stream_valid1", 160'(out_valid), 160'(1));
      check("stream_data1",  160'(out_data),  160'(1));
      check("stream_ctrl1",  160'(out_ctrl),  160'(10'h3FF));
      drive(1'b1, 10'h3FF, 128'd2);
      step();
      check("stream_data2", 160'(out_data), 160'(2));
      drive(1'b1, 10'h3FF, 128'd3);
      step();
      drive(1'b0, '0, '0);
      check("stream_data3",  160'(out_data),   160'(3));
      check("stream_bubble", 160'(bubble_cnt), 160'(1));
      step();
      check("stream_drained", 160'(sb_q.size()), 160'(0));
      check("stream_empty",   160'(out_bubble),  160'(1));

      // ---- Back-pressure: 10 held, 11 in skid, 12 waits upstream ----
      drive(1'b1, 10'h101, 128'd10);
      step();
      out_ready = 1'b0;
      drive(1'b1, 10'h102, 128'd11);
      step();
      check("bp_in_ready_low", 160'(in_ready), 160'(0));
      check("bp_hold10",       160'(out_data), 160'(10));
      drive(1'b1, 10'h103, 128'd12);
      repeat (3) step();
      check("bp_still_skid", 160'(in_ready),  160'(0));
      check("bp_still10",    160'(out_data),  160'(10));
      check("bp_stall4",     160'(stall_cnt), 160'(4));
      out_ready = 1'b1;
      step();
      check("bp_out11",       160'(out_data), 160'(11));
      check("bp_in_ready_up", 160'(in_ready), 160'(1));
      step();
      drive(1'b0, '0, '0);
      check("bp_out12", 160'(out_data), 160'(12));
      step();
      check("bp_drained",   160'(sb_q.size()), 160'(0));
      check("bp_stall_end", 160'(stall_cnt),   160'(4));

      // ---- Flush while in SKID, with an input presented ----
      out_ready = 1'b0;
      drive(1'b1, 10'h155, 128'h20);
      step();
      drive(1'b1, 10'h0AA, 128'h21);
      step();
      check("fl_in_skid", 160'(in_ready), 160'(0));
      drive(1'b1, 10'h3C3, 128'h55);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check("fl_out_valid",  160'(out_valid),  160'(0));
      check("fl_out_ctrl",   160'(out_ctrl),   160'(0));
      check("fl_out_data",   160'(out_data),   160'(0));
      check("fl_out_bubble", 160'(out_bubble), 160'(1));
      check("fl_in_ready",   160'(in_ready),   160'(1));
      check("fl_stall_kept", 160'(stall_cnt),  160'(6));
      out_ready = 1'b1;
      repeat (3) step();
      check("fl_nothing_out", 160'(out_valid), 160'(0));

      // ---- Flush together with a consume: 0x30 delivered, 0x31 dropped ----
      drive(1'b1, 10'h011, 128'h30);
      step();
      drive(1'b1, 10'h012, 128'h31);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check("flc_empty",    160'(out_valid), 160'(0));
      check("flc_in_ready", 160'(in_ready),  160'(1));
      repeat (2) step();
      check("flc_drained", 160'(sb_q.size()), 160'(0));

      // ---- Reset in the middle of a stall with SKID occupied ----
      out_ready = 1'b0;
      drive(1'b1, 10'h0F0, 128'h40);
      step();
      drive(1'b1, 10'h00F, 128'h41);
      step();
      check("rs_in_skid", 160'(in_ready), 160'(0));
      rst = 1'b0;
      step();
      rst = 1'b1;
      drive(1'b0, '0, '0);
      check_reset_state("rs_mid");
      out_ready = 1'b1;
      repeat (2) step();
      check("rs_nothing_out", 160'(out_valid), 160'(0));

      // ---- Saturation of a 4-bit stall counter ----
      s_rst       = 1'b1;
      s_in_valid  = 1'b1;
      s_in_ctrl   = 4'h9;
      s_in_data   = 8'hA5;
      s_out_ready = 1'b0;
      step();
      s_in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) check("sat_stall14", 160'(s_stall_cnt), 160'(14));
         if (i == 15) check("sat_stall15", 160'(s_stall_cnt), 160'(15));
      end
      check("sat_stall_hold", 160'(s_stall_cnt),  160'(15));
      check("sat_bubble",     160'(s_bubble_cnt), 160'(1));
      check("sat_data_held",  160'(s_out_data),   160'(8'hA5));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
